// File: rtl/pll_lock_supervisor.sv
// PLL lock supervisor: pulses PLL reset, waits for a stable lock, then releases core reset.
// Define PLL_SUPERVISOR_AUTORETRY_EN to re-pulse the PLL on lock timeout (up to MAX_RETRY times).
module pll_lock_supervisor #(
  parameter int RST_CYCLES   = 16,
  parameter int LOCK_TIMEOUT = 100000,
  parameter int HOLD_CYCLES  = 64,
  parameter int MAX_RETRY    = 7
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_locked,
  output logic       o_pll_rst,
  output logic       o_rst_core,
  output logic       o_lock_fail,
  output logic [3:0] o_retry_cnt
);

  localparam int MAX_A   = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
  localparam int MAX_CNT = (MAX_A > HOLD_CYCLES) ? MAX_A : HOLD_CYCLES;
  localparam int CW      = $clog2(MAX_CNT) + 1;

  localparam logic [CW-1:0] RST_LAST  = CW'(RST_CYCLES - 1);
  localparam logic [CW-1:0] TMO_LAST  = CW'(LOCK_TIMEOUT - 1);
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);

`ifdef PLL_SUPERVISOR_AUTORETRY_EN
  localparam bit AUTORETRY = 1'b1;
`else
  localparam bit AUTORETRY = 1'b0;
`endif
  localparam logic [3:0] RETRY_LIMIT = 4'(MAX_RETRY);

  typedef enum logic [2:0] {
    S_RESET_PLL = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_STABLE    = 3'd2,
    S_RUN       = 3'd3,
    S_FAIL      = 3'd4
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          locked_m, locked_s;
  logic          retry_ok;
  logic [3:0]    retry_inc;

  // Two-flop synchroniser; nothing downstream looks at i_locked directly.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      locked_m <= 1'b0;
      locked_s <= 1'b0;
    end else begin
      locked_m <= i_locked;
      locked_s <= locked_m;
    end
  end

  // Retry decision uses the count before this timeout is added.
  assign retry_ok  = AUTORETRY && (o_retry_cnt < RETRY_LIMIT);
  assign retry_inc = (o_retry_cnt == 4'hF) ? 4'hF : o_retry_cnt + 4'd1;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= S_RESET_PLL;
      cnt         <= '0;
      o_pll_rst   <= 1'b1;
      o_rst_core  <= 1'b1;
      o_lock_fail <= 1'b0;
      o_retry_cnt <= 4'd0;
    end else begin
      case (state)
        S_RESET_PLL: begin
          if (cnt == RST_LAST) begin
            state     <= S_WAIT_LOCK;
            cnt       <= '0;
            o_pll_rst <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        S_WAIT_LOCK: begin
          if (locked_s) begin
            // Lock beats a coincident timeout.
            state <= S_STABLE;
            cnt   <= '0;
          end else if (cnt == TMO_LAST) begin
            cnt         <= '0;
            o_retry_cnt <= retry_inc;
            o_pll_rst   <= 1'b1;
            if (retry_ok) begin
              state <= S_RESET_PLL;
            end else begin
              state       <= S_FAIL;
              o_lock_fail <= 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        S_STABLE: begin
          if (!locked_s) begin
            state <= S_WAIT_LOCK;
            cnt   <= '0;
          end else if (cnt == HOLD_LAST) begin
            state       <= S_RUN;
            cnt         <= '0;
            o_rst_core  <= 1'b0;
            o_retry_cnt <= 4'd0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        S_RUN: begin
          if (!locked_s) begin
            state      <= S_RESET_PLL;
            cnt        <= '0;
            o_pll_rst  <= 1'b1;
            o_rst_core <= 1'b1;
          end
        end

        S_FAIL: begin
          o_pll_rst   <= 1'b1;
          o_rst_core  <= 1'b1;
          o_lock_fail <= 1'b1;
        end

        default: begin
          state      <= S_RESET_PLL;
          cnt        <= '0;
          o_pll_rst  <= 1'b1;
          o_rst_core <= 1'b1;
        end
      endcase
    end
  end

  a_fail_outputs: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    o_lock_fail |-> (o_pll_rst && o_rst_core));
  a_run_core: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    (state == S_RUN) |-> !o_rst_core);

endmodule

// File: doc/pll_lock_supervisor.md
PLL_LOCK_SUPERVISOR -- requirements
Module: pll_lock_supervisor

Interface
REQ-001 SHALL have parameter RST_CYCLES, default 16: cycles o_pll_rst is held high per PLL reset pulse (min 1).
REQ-002 SHALL have parameter LOCK_TIMEOUT, default 100000: cycles allowed for lock after a PLL reset pulse.
REQ-003 SHALL have parameter HOLD_CYCLES, default 64: consecutive locked cycles required before releasing core reset.
REQ-004 SHALL have parameter MAX_RETRY, default 7: PLL reset retries allowed after the first timeout (1..15).
REQ-005 SHALL have port i_clk  input  1  free-running board clock; sole clock of the block.
REQ-006 SHALL have port i_rst_n  input  1  asynchronous, active-low reset.
REQ-007 SHALL have port i_locked  input  1  PLL LOCKED, asynchronous to i_clk.
REQ-008 SHALL have port o_pll_rst  output  1  registered PLL RST, active-high.
REQ-009 SHALL have port o_rst_core  output  1  registered core reset, active-high.
REQ-010 SHALL have port o_lock_fail  output  1  sticky failure flag.
REQ-011 SHALL have port o_retry_cnt  output  4  timeouts since last entry to RUN.

Function
REQ-012 SHALL synchronise i_locked through two flops (locked_s); 2-cycle latency; FSM uses locked_s only.
REQ-013 SHALL implement states RESET_PLL, WAIT_LOCK, STABLE, RUN, FAIL with one shared cycle counter, width $clog2 of the largest count parameter plus 1, cleared on every state change.
REQ-014 RESET_PLL: o_pll_rst=1 for exactly RST_CYCLES cycles, then WAIT_LOCK.
REQ-015 WAIT_LOCK: o_pll_rst=0; locked_s=1 -> STABLE; otherwise, after LOCK_TIMEOUT cycles -> timeout per REQ-021.
REQ-016 Timeout and locked_s=1 in the same cycle: lock wins (-> STABLE).
REQ-017 STABLE: locked_s=0 -> WAIT_LOCK (counter restarts, no retry increment); HOLD_CYCLES consecutive locked cycles -> RUN.
REQ-018 o_rst_core SHALL be 1 in all states except RUN, deasserting on the first RUN cycle.
REQ-019 RUN: locked_s=0 -> RESET_PLL; o_rst_core=1 on the first RESET_PLL cycle.
REQ-020 Entering RUN SHALL clear o_retry_cnt.
REQ-021 A timeout SHALL increment o_retry_cnt (saturating at 15).
REQ-022 FAIL: o_pll_rst=1, o_rst_core=1, o_lock_fail=1; exit only via i_rst_n.

Reset
REQ-023 While i_rst_n=0: state RESET_PLL, counter 0, o_pll_rst=1, o_rst_core=1, o_lock_fail=0, o_retry_cnt=0, sync flops 0.
REQ-024 Reset asserted mid-operation (any state, incl. FAIL) SHALL immediately force REQ-023 values; the RST_CYCLES pulse restarts from 0 after release.

Configuration
REQ-025 Macro PLL_SUPERVISOR_AUTORETRY_EN SHALL control retry on timeout.
REQ-026 With PLL_SUPERVISOR_AUTORETRY_EN defined: timeout with o_retry_cnt < MAX_RETRY (pre-increment) -> RESET_PLL; otherwise -> FAIL.
REQ-027 Without PLL_SUPERVISOR_AUTORETRY_EN: first timeout -> FAIL (o_retry_cnt still increments to 1); MAX_RETRY is ignored.

Verification (RST_CYCLES=4, LOCK_TIMEOUT=50, HOLD_CYCLES=8, MAX_RETRY=2)
REQ-028 Release i_rst_n, raise i_locked at cycle 10 -> o_pll_rst high cycles 0-3; o_rst_core falls 2+8 cycles after i_locked reaches STABLE; o_retry_cnt=0.
REQ-029 i_locked held 0, AUTORETRY_EN defined -> three 4-cycle o_pll_rst pulses spaced by 50-cycle timeouts; then FAIL with o_lock_fail=1, o_retry_cnt=3, o_pll_rst stuck at 1.
REQ-030 i_locked held 0, macro undefined -> one o_pll_rst pulse, one timeout, then FAIL, o_retry_cnt=1.
REQ-031 In RUN, drop i_locked for 1 cycle -> o_rst_core=1 within 3 cycles, new 4-cycle o_pll_rst pulse, RUN re-entered after relock plus 8 cycles.
REQ-032 In STABLE, glitch i_locked low at hold cycle 5 -> back to WAIT_LOCK, o_rst_core stays 1, o_retry_cnt unchanged; RUN entered only after 8 fresh locked cycles.
REQ-033 Assert i_rst_n=0 while in FAIL -> o_lock_fail=0, o_retry_cnt=0, o_pll_rst=1 immediately (asynchronous).
